captura_jogada: RTL and testbench

- Player-input receiver for the neurosync game. It sits between the raw `botoes[3:0]` inputs and the game control unit.
- Synchronizes and debounces the buttons and registers one one-hot play per press/release cycle.
- Flags multi-button presses as invalid and runs the per-play timeout.
- Arming and clearing are driven by the neurosync control unit.

---
 rtl/captura_jogada_pkg.sv | 22 ++
 rtl/captura_jogada_sincronizador_2ff.sv | 29 ++
 rtl/captura_jogada.sv | 187 ++++++++++++++++++
 tb/tb_captura_jogada.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/captura_jogada_pkg.sv
// Shared definitions for the neurosync player-input receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//   estado_t     : 3-bit state encoding, also the db_estado debug values
//   *_DEF        : default debounce/timeout lengths and button count
package captura_jogada_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 5;     // 5 ms at 1 kHz
    localparam int TIMEOUT_CYCLES_DEF  = 3000;  // 3 s at 1 kHz
    localparam int LARGURA_DEF         = 4;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ESPERA      = 3'd1,
        FILTRA_P    = 3'd2,
        PRESSIONADO = 3'd3,
        FILTRA_S    = 3'd4,
        FEITA       = 3'd5,
        ESGOTADO    = 3'd6
    } estado_t;

endpackage

// File: rtl/captura_jogada_sincronizador_2ff.sv
// Two-flop synchronizer bringing raw asynchronous buttons into the clock domain.
// Latency: 2 edges from first sample to dout.
// Backpressure: none; free-running.
//   clock, reset (async, active-low), din (raw), dout (synchronized)
module sincronizador_2ff #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] din,
    output logic [LARGURA-1:0] dout
);

    logic [LARGURA-1:0] meta_q;
    logic [LARGURA-1:0] sinc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= din;
            sinc_q <= meta_q;
        end
    end

    assign dout = sinc_q;

endmodule

// File: rtl/captura_jogada.sv
// Player-input receiver: syncs and debounces buttons, captures one one-hot play per press/release.
// Latency: press sampled at edge k loads jogada at k+2+DEBOUNCE_CYCLES; feita pulse one edge after release debounce.
// Backpressure: none; arming (habilita) and clearing (limpa) come from the control unit.
//   in : clock, reset (async active-low), limpa, habilita, botoes
//   out: jogada, jogada_feita, jogada_invalida, timeout, ocupado, db_estado
module captura_jogada
    import captura_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int LARGURA         = LARGURA_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpa,
    input  logic               habilita,
    input  logic [LARGURA-1:0] botoes,
    output logic [LARGURA-1:0] jogada,
    output logic               jogada_feita,
    output logic               jogada_invalida,
    output logic               timeout,
    output logic               ocupado,
    output logic [2:0]         db_estado
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic [LARGURA-1:0] bs;

    estado_t            estado_q, estado_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [LARGURA-1:0] cand_q, cand_d;
    logic [LARGURA-1:0] jogada_q, jogada_d;
    logic               invalida_q, invalida_d;   // current press was multi-hot
    logic               feita_q, feita_d;
    logic               jinv_q, jinv_d;

    logic [DW-1:0]      dcnt_inc;
    logic [TW-1:0]      tcnt_inc;
    logic               cand_one_hot;

    sincronizador_2ff #(.LARGURA(LARGURA)) u_sinc (
        .clock (clock),
        .reset (reset),
        .din   (botoes),
        .dout  (bs)
    );

    // Both counters saturate so a stuck state can never wrap into a false match.
    assign dcnt_inc     = (dcnt_q == D_MAX) ? dcnt_q : dcnt_q + DW'(1);
    assign tcnt_inc     = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + TW'(1);
    assign cand_one_hot = (cand_q != '0) && ((cand_q & (cand_q - LARGURA'(1))) == '0);

    always_comb begin
        estado_d   = estado_q;
        dcnt_d     = dcnt_q;
        tcnt_d     = tcnt_q;
        cand_d     = cand_q;
        jogada_d   = jogada_q;
        invalida_d = invalida_q;
        feita_d    = 1'b0;
        jinv_d     = 1'b0;

        if (limpa) begin
            estado_d   = OCIOSO;
            dcnt_d     = '0;
            tcnt_d     = '0;
            cand_d     = '0;
            jogada_d   = '0;
            invalida_d = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (habilita) begin
                        estado_d   = ESPERA;
                        dcnt_d     = '0;
                        tcnt_d     = '0;
                        invalida_d = 1'b0;
                    end
                end
                ESPERA: begin
                    tcnt_d = tcnt_inc;
                    if (tcnt_inc == T_MAX) begin
                        estado_d = ESGOTADO;
                    end else if (bs != '0) begin
                        cand_d   = bs;
                        dcnt_d   = DW'(1);
                        estado_d = FILTRA_P;
                    end
                end
                FILTRA_P: begin
                    tcnt_d = tcnt_inc;
                    // Acceptance is checked before the timeout so a press that
                    // finishes debouncing on the deadline edge still counts.
                    if (dcnt_q == D_MAX) begin
                        if (cand_one_hot) begin
                            jogada_d   = cand_q;
                            invalida_d = 1'b0;
                        end else begin
                            jinv_d     = 1'b1;
                            invalida_d = 1'b1;
                        end
                        estado_d = PRESSIONADO;
                    end else if (tcnt_inc == T_MAX) begin
                        estado_d = ESGOTADO;
                    end else if (bs == cand_q) begin
                        dcnt_d = dcnt_inc;
                    end else if (bs != '0) begin
                        cand_d = bs;
                        dcnt_d = DW'(1);
                    end else begin
                        // Glitch: keep the running timeout, restart the search.
                        dcnt_d   = '0;
                        estado_d = ESPERA;
                    end
                end
                PRESSIONADO: begin
                    if (bs == '0) begin
                        dcnt_d   = DW'(1);
                        estado_d = FILTRA_S;
                    end
                end
                FILTRA_S: begin
                    if (dcnt_q == D_MAX) begin
                        if (invalida_q) begin
                            // Invalid play: re-arm with a fresh timeout window.
                            estado_d   = ESPERA;
                            dcnt_d     = '0;
                            tcnt_d     = '0;
                            invalida_d = 1'b0;
                        end else begin
                            estado_d = FEITA;
                        end
                    end else if (bs == '0) begin
                        dcnt_d = dcnt_inc;
                    end else begin
                        estado_d = PRESSIONADO;
                    end
                end
                FEITA: begin
                    feita_d  = 1'b1;
                    estado_d = OCIOSO;
                end
                ESGOTADO: begin
                    estado_d = ESGOTADO;
                end
                default: begin
                    estado_d = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            dcnt_q     <= '0;
            tcnt_q     <= '0;
            cand_q     <= '0;
            jogada_q   <= '0;
            invalida_q <= 1'b0;
            feita_q    <= 1'b0;
            jinv_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            dcnt_q     <= dcnt_d;
            tcnt_q     <= tcnt_d;
            cand_q     <= cand_d;
            jogada_q   <= jogada_d;
            invalida_q <= invalida_d;
            feita_q    <= feita_d;
            jinv_q     <= jinv_d;
        end
    end

    assign jogada          = jogada_q;
    assign jogada_feita    = feita_q;
    assign jogada_invalida = jinv_q;
    assign timeout         = (estado_q == ESGOTADO);
    assign ocupado         = (estado_q != OCIOSO) && (estado_q != ESGOTADO);
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada with a pulse scoreboard.
module tb_captura_jogada;
    import captura_jogada_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       limpa = 1'b0;
    logic       habilita = 1'b0;
    logic [3:0] botoes = 4'b0000;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic       timeout;
    logic       ocupado;
    logic [2:0] db_estado;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        bit         inval;
        logic [3:0] jog;
        int         ciclo;
    } ev_t;
    ev_t exp_q[$];

    captura_jogada #(
        .DEBOUNCE_CYCLES (5),
        .TIMEOUT_CYCLES  (3000),
        .LARGURA         (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .limpa           (limpa),
        .habilita        (habilita),
        .botoes          (botoes),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .timeout         (timeout),
        .ocupado         (ocupado),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic arm();
        habilita = 1'b1;
        tick(1);
        habilita = 1'b0;
        chk("arm_estado", db_estado, ESPERA);
        chk("arm_ocupado", ocupado, 1'b1);
    endtask

    // Scoreboard consumer: every pulse must match the oldest expected event.
    always @(negedge clock) begin
        if (reset === 1'b1 && (jogada_feita === 1'b1 || jogada_invalida === 1'b1)) begin
            if (exp_q.size() == 0) begin
                chk("pulso_espurio", {30'b0, jogada_feita, jogada_invalida}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("evt_invalida", jogada_invalida, e.inval);
                chk("evt_feita", jogada_feita, !e.inval);
                chk("evt_jogada", jogada, e.jog);
                chk("evt_ciclo", cyc, e.ciclo);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, observed cycle %0d required < 50000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;

        // Reset state
        tick(2);
        chk("rst_jogada", jogada, 4'b0000);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_estado", db_estado, OCIOSO);
        chk("rst_ocupado", ocupado, 1'b0);
        chk("rst_pulsos", {jogada_feita, jogada_invalida}, 2'b00);
        reset = 1'b1;
        tick(2);

        // Clean press of button 0
        arm();
        e = cyc;
        botoes = 4'b0001;
        tick(7);
        chk("limpo_antes", jogada, 4'b0000);
        chk("limpo_filtra", db_estado, FILTRA_P);
        tick(1);
        chk("limpo_jogada", jogada, 4'b0001);
        chk("limpo_press", db_estado, PRESSIONADO);
        tick(2);
        botoes = 4'b0000;
        exp_q.push_back('{inval: 1'b0, jog: 4'b0001, ciclo: cyc + 9});
        tick(12);
        chk("limpo_ocioso", db_estado, OCIOSO);
        chk("limpo_retido", jogada, 4'b0001);
        chk("limpo_fila", exp_q.size(), 0);

        // Async reset in the middle of debouncing
        arm();
        botoes = 4'b0010;
        tick(4);
        chk("rstm_filtra", db_estado, FILTRA_P);
        reset = 1'b0;
        #1;
        chk("rstm_jogada", jogada, 4'b0000);
        chk("rstm_timeout", timeout, 1'b0);
        chk("rstm_estado", db_estado, OCIOSO);
        tick(2);
        reset = 1'b1;
        tick(3);
        botoes = 4'b0000;
        tick(12);
        chk("rstm_ocioso", db_estado, OCIOSO);
        chk("rstm_jogada2", jogada, 4'b0000);

        // Short glitch on button 2 then a real press of button 3
        arm();
        botoes = 4'b0100;
        tick(3);
        botoes = 4'b1000;
        tick(7);
        chk("glitch_antes", jogada, 4'b0000);
        tick(1);
        chk("glitch_jogada", jogada, 4'b1000);
        tick(2);
        botoes = 4'b0000;
        exp_q.push_back('{inval: 1'b0, jog: 4'b1000, ciclo: cyc + 9});
        tick(12);
        chk("glitch_ocioso", db_estado, OCIOSO);
        chk("glitch_fila", exp_q.size(), 0);

        // Multi-hot press: invalid pulse, jogada kept, re-armed afterwards
        arm();
        botoes = 4'b0110;
        exp_q.push_back('{inval: 1'b1, jog: 4'b1000, ciclo: cyc + 8});
        tick(8);
        chk("inv_jogada", jogada, 4'b1000);
        chk("inv_press", db_estado, PRESSIONADO);
        tick(2);
        botoes = 4'b0000;
        tick(8);
        chk("inv_rearmado", db_estado, ESPERA);
        chk("inv_jogada2", jogada, 4'b1000);
        tick(5);
        chk("inv_espera", db_estado, ESPERA);
        chk("inv_fila", exp_q.size(), 0);
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
        chk("inv_limpa_estado", db_estado, OCIOSO);
        chk("inv_limpa_jogada", jogada, 4'b0000);

        // Timeout with no input
        arm();
        tick(2999);
        chk("to_antes_estado", db_estado, ESPERA);
        chk("to_antes", timeout, 1'b0);
        tick(1);
        chk("to_estado", db_estado, ESGOTADO);
        chk("to_nivel", timeout, 1'b1);
        chk("to_ocupado", ocupado, 1'b0);
        botoes = 4'b0001;
        habilita = 1'b1;
        tick(20);
        chk("to_ignora_estado", db_estado, ESGOTADO);
        chk("to_ignora_nivel", timeout, 1'b1);
        chk("to_ignora_jogada", jogada, 4'b0000);
        botoes = 4'b0000;
        habilita = 1'b0;
        tick(5);
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
        chk("to_limpa_nivel", timeout, 1'b0);
        chk("to_limpa_estado", db_estado, OCIOSO);

        // Debounce acceptance on the same edge the timeout would fire
        arm();
        tick(2992);
        botoes = 4'b0001;
        tick(7);
        chk("corrida_filtra", db_estado, FILTRA_P);
        tick(1);
        chk("corrida_jogada", jogada, 4'b0001);
        chk("corrida_timeout", timeout, 1'b0);
        chk("corrida_press", db_estado, PRESSIONADO);
        tick(5);
        chk("corrida_timeout2", timeout, 1'b0);
        botoes = 4'b0000;
        exp_q.push_back('{inval: 1'b0, jog: 4'b0001, ciclo: cyc + 9});
        tick(12);
        chk("corrida_ocioso", db_estado, OCIOSO);

        chk("fila_final", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
